// File: rtl/game_pkg.sv
// Shared encodings for the game-flow controller and its movement datapath.
// No logic of its own; constants and a direction-encode helper only.
// Consumers import with game_pkg::*.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  // One-hot move command, bit order {up,down,left,right}
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  localparam int ENEMY_ID_W = 3;

  // Keep only the highest-priority pressed button: up > down > left > right
  function automatic logic [3:0] encode_dir(input logic [3:0] btn);
    logic [3:0] dir;
    dir = DIR_NONE;
    if (btn[3])      dir = DIR_UP;
    else if (btn[2]) dir = DIR_DOWN;
    else if (btn[1]) dir = DIR_LEFT;
    else if (btn[0]) dir = DIR_RIGHT;
    return dir;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_tick_prescaler.sv
// Free-running divider producing the movement tick once every TICK_DIV clocks.
// Latency: tick is a combinational decode of the counter, high while count==TICK_DIV-1.
// Backpressure: none; the counter never stalls.
module tick_prescaler #(
  parameter int TICK_DIV = 833333,
  parameter int CNT_W    = 20
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_LAST);

  // Count 0..TICK_DIV-1 and wrap on the tick cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow FSM: movement strobes, lives, hit freeze, win/over and respawn.
// Latency: every output is registered, one cycle after its causing condition.
// Backpressure: none; the movement datapath must accept each one-cycle strobe.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 833333,
  parameter int CNT_W      = 20,
  parameter int LIVES_INIT = 3,
  parameter int LIVES_W    = 2,
  parameter int HIT_TICKS  = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            btn_dir,
  input  logic                  enemy_collide,
  input  logic [ENEMY_ID_W-1:0] collide_id,
  input  logic                  win,
  output logic [3:0]            move_dir,
  output logic                  move_tick,
  output logic                  respawn,
  output logic [LIVES_W-1:0]    lives,
  output logic [2:0]            state,
  output logic [ENEMY_ID_W-1:0] hit_id,
  output logic                  game_over
);

  localparam int FRZ_W = $clog2(HIT_TICKS + 1);
  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [FRZ_W-1:0]   FRZ_LOAD   = FRZ_W'(HIT_TICKS);
  localparam logic [FRZ_W-1:0]   FRZ_LAST   = FRZ_W'(1);

  logic tick;
  logic start_q;
  logic start_rise;

  state_t                  st_q,    st_d;
  logic [LIVES_W-1:0]      lives_d;
  logic [ENEMY_ID_W-1:0]   hit_id_d;
  logic [FRZ_W-1:0]        frz_q,   frz_d;
  logic [3:0]              move_dir_d;
  logic                    move_tick_d;
  logic                    respawn_d;
  logic                    game_over_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign start_rise = start & ~start_q;
  assign state      = st_q;

  // Next-state and next-output decode; everything defaults to "hold, no pulse"
  always_comb begin
    st_d        = st_q;
    lives_d     = lives;
    hit_id_d    = hit_id;
    frz_d       = frz_q;
    move_dir_d  = DIR_NONE;
    move_tick_d = 1'b0;
    respawn_d   = 1'b0;
    case (st_q)
      ST_IDLE, ST_WIN, ST_OVER: begin
        if (start_rise) begin
          lives_d   = LIVES_LOAD;
          st_d      = ST_PLAY;
          respawn_d = 1'b1;
        end
      end
      ST_PLAY: begin
        // win beats a hit, a hit beats a move; start is ignored while playing
        if (win) begin
          st_d = ST_WIN;
        end else if (enemy_collide) begin
          st_d     = ST_HIT;
          lives_d  = lives - 1'b1;
          hit_id_d = collide_id;
          frz_d    = FRZ_LOAD;
        end else if (tick) begin
          move_tick_d = 1'b1;
          move_dir_d  = encode_dir(btn_dir);
        end
      end
      ST_HIT: begin
        // Frozen: count ticks down, then respawn or end the game
        if (tick) begin
          frz_d = frz_q - 1'b1;
          if (frz_q == FRZ_LAST) begin
            if (lives == '0) begin
              st_d = ST_OVER;
            end else begin
              st_d      = ST_PLAY;
              respawn_d = 1'b1;
            end
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
    game_over_d = (st_d == ST_OVER);
  end

  // State and registered outputs; reset aborts any game in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      lives     <= LIVES_LOAD;
      hit_id    <= '0;
      frz_q     <= '0;
      start_q   <= 1'b0;
      move_dir  <= DIR_NONE;
      move_tick <= 1'b0;
      respawn   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      st_q      <= st_d;
      lives     <= lives_d;
      hit_id    <= hit_id_d;
      frz_q     <= frz_d;
      start_q   <= start;
      move_dir  <= move_dir_d;
      move_tick <= move_tick_d;
      respawn   <= respawn_d;
      game_over <= game_over_d;
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized bench for game_flow_ctrl against a cycle-level behavioural model.
// Model tracks game state as plain integers; tick phase comes from a cycle count.
// Outputs are compared 1 time unit after every rising edge.
module tb_game_flow_ctrl;

  localparam int TD = 4;
  localparam int HT = 2;
  localparam int LI = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] btn_dir;
  logic       enemy_collide;
  logic [2:0] collide_id;
  logic       win;
  logic [3:0] move_dir;
  logic       move_tick;
  logic       respawn;
  logic [1:0] lives;
  logic [2:0] state;
  logic [2:0] hit_id;
  logic       game_over;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: 0 idle, 1 play, 2 hit, 3 win, 4 over
  int m_state, m_lives, m_hit, m_freeze, m_cyc, m_start_q;
  int e_tick, e_dir, e_resp;

  game_flow_ctrl #(
    .TICK_DIV   (TD),
    .CNT_W      (3),
    .LIVES_INIT (LI),
    .LIVES_W    (2),
    .HIT_TICKS  (HT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .btn_dir       (btn_dir),
    .enemy_collide (enemy_collide),
    .collide_id    (collide_id),
    .win           (win),
    .move_dir      (move_dir),
    .move_tick     (move_tick),
    .respawn       (respawn),
    .lives         (lives),
    .state         (state),
    .hit_id        (hit_id),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int highest_dir(input logic [3:0] b);
    for (int i = 3; i >= 0; i--)
      if (b[i]) return (1 << i);
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lives = LI; m_hit = 0; m_freeze = 0;
    m_cyc = 0; m_start_q = 0;
    e_tick = 0; e_dir = 0; e_resp = 0;
  endtask

  // One clock edge of the game rules, using the inputs seen at that edge
  task automatic model_step();
    bit rise, tk;
    if (rst) begin
      model_reset();
      return;
    end
    rise = start && (m_start_q == 0);
    tk   = (m_cyc % TD) == (TD - 1);
    m_start_q = start ? 1 : 0;
    e_tick = 0; e_dir = 0; e_resp = 0;
    if (m_state == 1) begin
      if (win) m_state = 3;
      else if (enemy_collide) begin
        m_state = 2; m_lives = m_lives - 1; m_hit = collide_id; m_freeze = HT;
      end else if (tk) begin
        e_tick = 1; e_dir = highest_dir(btn_dir);
      end
    end else if (m_state == 2) begin
      if (tk) begin
        if (m_freeze == 1) begin
          if (m_lives == 0) m_state = 4;
          else begin m_state = 1; e_resp = 1; end
        end
        m_freeze = m_freeze - 1;
      end
    end else if (rise) begin
      m_lives = LI; m_state = 1; e_resp = 1;
    end
    m_cyc++;
  endtask

  task automatic compare_all();
    check_val("move_tick", move_tick, e_tick);
    check_val("move_dir",  move_dir,  e_dir);
    check_val("respawn",   respawn,   e_resp);
    check_val("lives",     lives,     m_lives);
    check_val("state",     state,     m_state);
    check_val("hit_id",    hit_id,    m_hit);
    check_val("game_over", game_over, (m_state == 4) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n, input bit rand_btn);
    for (int i = 0; i < n; i++) begin
      if (rand_btn) btn_dir = 4'($urandom_range(0, 15));
      cycle();
    end
  endtask

  task automatic pulse_collide(input logic [2:0] id);
    enemy_collide = 1'b1; collide_id = id;
    cycle();
    enemy_collide = 1'b0; collide_id = 3'd0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; btn_dir = 4'd0;
    enemy_collide = 1'b0; collide_id = 3'd0; win = 1'b0;
    model_reset();
    #1;
    compare_all();
    cycles(2, 1'b0);
    rst = 1'b0;
    cycles(5, 1'b1);

    // 1: start with up held
    btn_dir = 4'b1000; start = 1'b1;
    cycle();
    start = 1'b0;
    cycles(12, 1'b0);

    // 2: priority encoding of multiple presses
    btn_dir = 4'b1011;
    cycles(10, 1'b0);
    btn_dir = 4'b0011;
    cycles(10, 1'b0);

    // 3: first hit, freeze, respawn
    pulse_collide(3'd3);
    cycles(12, 1'b1);

    // 4: last life lost, game over, held start restarts once
    pulse_collide(3'($urandom_range(1, 5)));
    cycles(12, 1'b1);
    start = 1'b1;
    cycles(20, 1'b1);
    start = 1'b0;
    cycles(5, 1'b1);

    // 5: win and collide together on a tick edge
    for (int i = 0; i < 8; i++) begin
      if ((m_cyc % TD) == (TD - 1)) break;
      cycle();
    end
    win = 1'b1; enemy_collide = 1'b1; collide_id = 3'd5;
    cycle();
    win = 1'b0; enemy_collide = 1'b0; collide_id = 3'd0;
    cycles(3, 1'b1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycles(6, 1'b1);

    // 6: reset in the middle of the freeze
    pulse_collide(3'd2);
    for (int i = 0; i < 20; i++) begin
      if (m_state == 2 && m_freeze == 1) break;
      cycle();
    end
    check_val("freeze_reached", (m_state == 2 && m_freeze == 1) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    cycle();
    rst = 1'b0;
    cycles(10, 1'b1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycles(8, 1'b1);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      start         = ($urandom_range(0, 15) == 0);
      btn_dir       = 4'($urandom_range(0, 15));
      enemy_collide = ($urandom_range(0, 19) == 0);
      collide_id    = 3'($urandom_range(1, 5));
      win           = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Sequences the player-movement datapath. It generates the movement tick, gates and encodes the button direction into the one-hot move command the movement datapath consumes, and runs the game-flow FSM (idle, play, hit-freeze, win, game over). It also owns the lives counter and the player respawn pulse. It sits between the board buttons and the movement/collision datapath, and drives the display/status logic.

Parameters:
TICK_DIV, 833333, clocks per movement tick (60 Hz at 50 MHz); must be >= 2
CNT_W, 20, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV
LIVES_INIT, 3, lives loaded at game start; must be >= 1
LIVES_W, 2, lives counter width
HIT_TICKS, 60, freeze length after an enemy hit, in ticks; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  start/restart button, level, already debounced and synchronous
btn_dir  in  4  raw direction buttons {up,down,left,right}, synchronous
enemy_collide  in  1  player/enemy contact flag from the movement datapath
collide_id  in  3  enemy index 1..5 of the contact; 0 = none
win  in  1  goal-reached flag
move_dir  out  4  one-hot move command {up,down,left,right}; valid only while move_tick=1
move_tick  out  1  one-cycle movement strobe
respawn  out  1  one-cycle pulse: datapath reloads the player start position
lives  out  LIVES_W  remaining lives
state  out  3  IDLE=0, PLAY=1, HIT=2, WIN=3, OVER=4
hit_id  out  3  latched collide_id of the last hit
game_over  out  1  high while state==OVER

Behaviour:
- Reset values: state=IDLE, lives=LIVES_INIT, move_dir=0, move_tick=0, respawn=0, hit_id=0, game_over=0, prescaler=0, freeze=0, start_q=0. Reset asserted mid-game aborts the game immediately, with no pending pulses.
- Prescaler: free-running in every state. Counts 0..TICK_DIV-1. The internal tick is high in the cycle where count==TICK_DIV-1, then the count wraps to 0.
- start_q registers start. start_rise = start & ~start_q. A held start never retriggers.
- Direction encode priority is up > down > left > right. Multiple presses yield only the highest-priority bit. No press yields 0000.
- All outputs are registered. move_tick, move_dir and respawn are asserted in the cycle after the causing condition and last exactly one cycle.
- IDLE: on start_rise, load lives=LIVES_INIT, go to PLAY, and pulse respawn.
- PLAY: win and enemy_collide are evaluated every cycle. Priority is win > enemy_collide > tick.
  - win=1 -> WIN. No move is issued, even on a tick cycle.
  - else enemy_collide=1 -> HIT. lives <= lives-1, hit_id <= collide_id, freeze <= HIT_TICKS, no move issued.
  - else on tick: move_tick=1 and move_dir=encoded btn_dir. move_tick still pulses when btn_dir=0000.
  - start is ignored in PLAY.
- HIT: no moves and no move_tick. On each tick, freeze decrements. On the tick where freeze==1:
  - lives==0 -> OVER.
  - else -> PLAY, with respawn pulsed.
  - enemy_collide and win are ignored in HIT.
- WIN / OVER: hold, with move_tick=0. On start_rise: lives=LIVES_INIT, state PLAY, respawn pulsed.
- game_over is the registered decode of state==OVER.
- lives never underflows: it is decremented only on the PLAY->HIT transition, and PLAY is only entered with lives>=1.
- Simultaneous events:
  - start_rise in the same cycle as win or collide while in PLAY: start is ignored.
  - collide in the same cycle as a tick: collide wins and no move is issued.

Decomposition:
- Shared package (game_pkg) holds:
  - state encodings ST_IDLE..ST_OVER;
  - one-hot direction constants DIR_UP=1000, DIR_DOWN=0100, DIR_LEFT=0010, DIR_RIGHT=0001, DIR_NONE=0000;
  - 3-bit enemy-id width.
- One sub-module, tick_prescaler (parameters TICK_DIV and CNT_W; ports clk, rst, tick). Everything else stays in game_flow_ctrl.

Test Plan (bench overrides: TICK_DIV=4, HIT_TICKS=2, LIVES_INIT=2):
1. Reset, then start pulse with btn_dir=1000 held -> respawn one cycle; state=1; move_tick every 4 clocks with move_dir=1000; lives=2.
2. btn_dir=1011 in PLAY -> every move_tick carries move_dir=1000. Switch to btn_dir=0011 -> move_dir=0010.
3. enemy_collide=1, collide_id=3 for one cycle in PLAY -> state=2, lives=1, hit_id=3, no move_tick for 2 ticks, then state=1 with one respawn pulse.
4. A second collide with lives=1 -> lives=0, state=2; after 2 ticks state=4, game_over=1. start held high -> one restart only: state=1, lives=2, respawn pulse.
5. win=1 and enemy_collide=1 together on a tick cycle -> state=3, lives unchanged, no move_tick. start_rise -> state=1, lives=2.
6. Assert rst mid-HIT (freeze=1) -> all outputs at reset values in the same cycle. After release, no respawn until start_rise.
